// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative MIPS divider sequencer:
// state encoding and default operand width.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage divide request, hazard stall and HI/LO write bundle.
// master = es/hazard/HI-LO side, slave = divider sequencer.
interface div_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             es_valid;
    logic             es_div;
    logic             es_div_signed;
    logic [WIDTH-1:0] es_src1;
    logic [WIDTH-1:0] es_src2;
    logic             exc_flush;
    logic             div_block;
    logic             busy;
    logic             hilo_we;
    logic [WIDTH-1:0] lo_wdata;
    logic [WIDTH-1:0] hi_wdata;

    modport master (
        output es_valid, es_div, es_div_signed, es_src1, es_src2, exc_flush,
        input  div_block, busy, hilo_we, lo_wdata, hi_wdata
    );

    modport slave (
        input  es_valid, es_div, es_div_signed, es_src1, es_src2, exc_flush,
        output div_block, busy, hilo_we, lo_wdata, hi_wdata
    );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider sequencer for DIV/DIVU: one quotient bit per
// cycle on magnitudes, sign fix-up applied when the HI/LO pulse is issued.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      resetn,
    div_ctrl_if.slave dif
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             q_neg, r_neg;
    logic             start, run_abort, last_step;
    logic [WIDTH-1:0] src1_mag, src2_mag;
    logic [WIDTH:0]   trial;

    assign start     = dif.es_valid & dif.es_div & ~dif.exc_flush;
    assign run_abort = dif.exc_flush | ~(dif.es_valid & dif.es_div);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign src1_mag  = (dif.es_div_signed & dif.es_src1[WIDTH-1]) ? -dif.es_src1 : dif.es_src1;
    assign src2_mag  = (dif.es_div_signed & dif.es_src2[WIDTH-1]) ? -dif.es_src2 : dif.es_src2;
    // Borrow out (trial[WIDTH]) means the divisor did not fit: restore.
    assign trial     = {rem, quo[WIDTH-1]} - {1'b0, dvs};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (run_abort)      state_nxt = IDLE;
                else if (last_step) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dif.busy      = (state != IDLE);
        dif.div_block = dif.es_valid & dif.es_div & (state != DONE);
        dif.hilo_we   = (state == DONE) & ~dif.exc_flush;
        dif.lo_wdata  = q_neg ? -quo : quo;
        dif.hi_wdata  = r_neg ? -rem : rem;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                cnt   <= '0;
                rem   <= '0;
                quo   <= src1_mag;
                dvs   <= src2_mag;
                q_neg <= dif.es_div_signed & (dif.es_src1[WIDTH-1] ^ dif.es_src2[WIDTH-1]);
                r_neg <= dif.es_div_signed & dif.es_src1[WIDTH-1];
            end
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
            end else begin
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            end
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed corner cases plus random DIV/DIVU traffic
// compared against a plain-arithmetic reference quotient/remainder.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn;
    int   n_chk  = 0;
    int   n_pass = 0;

    div_ctrl_if #(.WIDTH(W)) dif ();

    div_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .dif    (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: MIPS semantics via 64-bit arithmetic (C-style truncation).
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sgn,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            r = a;
            q = (sgn && a[W-1]) ? W'(1) : '1;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'(a);
            sb = sgn ? longint'($signed(b)) : longint'(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
    endfunction

    task automatic idle_inputs();
        dif.es_valid      = 1'b0;
        dif.es_div        = 1'b0;
        dif.es_div_signed = 1'b0;
        dif.es_src1       = '0;
        dif.es_src2       = '0;
        dif.exc_flush     = 1'b0;
    endtask

    // Entered and left just after a rising edge.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input bit flush_done, input bit keep, input string tag);
        logic [W-1:0] q, r;
        int blocks, early_we;
        ref_div(a, b, sgn, q, r);
        dif.es_valid      = 1'b1;
        dif.es_div        = 1'b1;
        dif.es_div_signed = sgn;
        dif.es_src1       = a;
        dif.es_src2       = b;
        dif.exc_flush     = 1'b0;
        @(negedge clk);
        check({tag, ".start_busy"}, 64'(dif.busy), 64'd0);
        blocks   = 0;
        early_we = 0;
        while (dif.div_block && blocks < 60) begin
            blocks++;
            if (dif.hilo_we) early_we++;
            @(posedge clk); #1;
            if (flush_done && blocks == W + 1) dif.exc_flush = 1'b1;
            @(negedge clk);
        end
        check({tag, ".block_cycles"}, 64'(blocks), 64'(W + 1));
        check({tag, ".early_we"}, 64'(early_we), 64'd0);
        check({tag, ".done_busy"}, 64'(dif.busy), 64'd1);
        check({tag, ".hilo_we"}, 64'(dif.hilo_we), 64'(!flush_done));
        if (!flush_done) begin
            check({tag, ".lo"}, 64'(dif.lo_wdata), 64'(q));
            check({tag, ".hi"}, 64'(dif.hi_wdata), 64'(r));
        end
        @(posedge clk); #1;
        dif.exc_flush = 1'b0;
        if (!keep) begin
            idle_inputs();
            @(negedge clk);
            check({tag, ".post_busy"}, 64'(dif.busy), 64'd0);
            check({tag, ".post_we"}, 64'(dif.hilo_we), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    // Abort in RUN cycle `at` by flush (use_flush) or by es_div dropping.
    task automatic abort_div(input logic [W-1:0] a, input logic [W-1:0] b, input int at,
                             input bit use_flush, input string tag);
        int we_seen;
        dif.es_valid      = 1'b1;
        dif.es_div        = 1'b1;
        dif.es_div_signed = 1'b0;
        dif.es_src1       = a;
        dif.es_src2       = b;
        dif.exc_flush     = 1'b0;
        we_seen = 0;
        @(negedge clk);
        for (int k = 1; k <= at; k++) begin
            @(posedge clk); #1;
            if (k == at) begin
                if (use_flush) dif.exc_flush = 1'b1;
                else           dif.es_div    = 1'b0;
            end
            @(negedge clk);
            if (dif.hilo_we) we_seen++;
        end
        check({tag, ".run_busy"}, 64'(dif.busy), 64'd1);
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, ".idle_busy"}, 64'(dif.busy), 64'd0);
            if (dif.hilo_we) we_seen++;
        end
        check({tag, ".no_we"}, 64'(we_seen), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        bit           rk;

        resetn = 1'b0;
        idle_inputs();
        #12;
        check("rst.busy", 64'(dif.busy), 64'd0);
        check("rst.we", 64'(dif.hilo_we), 64'd0);
        check("rst.block", 64'(dif.div_block), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        do_div(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, "divu_100_7");
        do_div(-32'sd7, 32'd2, 1'b1, 1'b0, 1'b0, "div_m7_2");
        do_div(32'd7, -32'sd2, 1'b1, 1'b0, 1'b0, "div_7_m2");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "div_min_m1");
        do_div(32'd5, 32'd0, 1'b0, 1'b0, 1'b0, "divu_5_0");
        do_div(-32'sd7, 32'd0, 1'b1, 1'b0, 1'b0, "div_m7_0");

        abort_div(32'd1234, 32'd5, 10, 1'b1, "abort_flush");
        do_div(32'd9, 32'd3, 1'b0, 1'b0, 1'b0, "divu_9_3");
        abort_div(32'd777, 32'd11, 5, 1'b0, "abort_drop");

        do_div(32'd1000, 32'd33, 1'b0, 1'b0, 1'b1, "b2b_first");
        do_div(32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0, 1'b0, "b2b_second");
        do_div(32'd50, 32'd5, 1'b0, 1'b1, 1'b0, "flush_done");

        // Reset in the middle of RUN.
        dif.es_valid = 1'b1;
        dif.es_div   = 1'b1;
        dif.es_src1  = 32'd4000;
        dif.es_src2  = 32'd3;
        @(negedge clk);
        for (int k = 1; k < 20; k++) @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        idle_inputs();
        #1;
        check("midrst.busy", 64'(dif.busy), 64'd0);
        check("midrst.we", 64'(dif.hilo_we), 64'd0);
        check("midrst.block", 64'(dif.div_block), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("postrst.busy", 64'(dif.busy), 64'd0);
        check("postrst.block", 64'(dif.div_block), 64'd0);
        @(posedge clk); #1;
        do_div(32'd9, 32'd3, 1'b0, 1'b0, 1'b0, "postrst_9_3");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = W'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            rk = ($urandom_range(0, 3) == 0);
            do_div(ra, rb, rs, 1'b0, rk, $sformatf("rnd%0d", i));
        end
        idle_inputs();
        @(negedge clk);
        check("end.busy", 64'(dif.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer for the iterative MIPS divider shared by DIV/DIVU in the execute stage. It accepts a divide from es, raises `div_block` to the hazard unit so that ds and es stall for the whole operation, and runs a radix-2 restoring division over WIDTH cycles. It then delivers quotient and remainder as a one-cycle HI/LO write pulse. An exception/eret flush aborts it at any point.

## Interface
- `WIDTH`, default 32: operand width. The iteration count equals WIDTH.
- `clk` input 1: single clock.
- `resetn` input 1: asynchronous, active-low reset.
- `es_valid` input 1: es holds a valid instruction.
- `es_div` input 1: the es instruction is DIV or DIVU.
- `es_div_signed` input 1: 1 for DIV, 0 for DIVU.
- `es_src1` input WIDTH: dividend (rs).
- `es_src2` input WIDTH: divisor (rt).
- `exc_flush` input 1: exception or eret flush from m2s.
- `div_block` output 1: stall request to the hazard unit.
- `busy` output 1: state != IDLE.
- `hilo_we` output 1: one-cycle write strobe for HI and LO.
- `lo_wdata` output WIDTH: quotient.
- `hi_wdata` output WIDTH: remainder.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - A start occurs when `es_valid & es_div & !exc_flush`.
  - On start, latch the magnitudes: rem = 0, quo = |src1|, dvs = |src2|. For DIVU the magnitudes are the raw values.
  - Also latch q_neg = signed & (src1[msb] ^ src2[msb]) and r_neg = signed & src1[msb].
  - Clear cnt and go to RUN.
- **RUN**, one step per cycle:
  - t = {rem, quo[msb]} − {1'b0, dvs}, computed in WIDTH+1 bits.
  - If t is non-negative: rem = t[WIDTH-1:0] and quo = {quo[WIDTH-2:0], 1}.
  - Otherwise: rem = {rem[WIDTH-2:0], quo[msb]} and quo = {quo[WIDTH-2:0], 0}.
  - cnt increments each step. When the step with cnt == WIDTH−1 completes, go to DONE.
- **DONE**
  - `hilo_we` = !exc_flush.
  - lo_wdata = q_neg ? −quo : quo.
  - hi_wdata = r_neg ? −rem : rem.
  - Go to IDLE in the next cycle unconditionally.
- `div_block` = es_valid & es_div & (state != DONE). This is combinational, so the start cycle already blocks.
- **Abort**: if `exc_flush` is asserted, or es_valid/es_div drops while in RUN, go to IDLE in the next cycle with no write.
- **Divide by zero**: no special case. The algorithm yields |q| = all ones and r = |dividend|, then the sign fix is applied.
- **0x80000000 / −1 signed**: the result is q = 0x80000000, r = 0, with no trap.
- **Reset**: asynchronous. The state goes to IDLE, cnt, rem, quo and dvs are cleared, and `hilo_we`, `busy` and `div_block` (given es_valid = 0) are all 0. Reset mid-RUN discards the operation.

## Timing
- A start in cycle T is followed by RUN in cycles T+1 through T+WIDTH, and DONE in cycle T+WIDTH+1. For WIDTH = 32, DONE is T+33.
- `div_block` is high from T through T+WIDTH, and low in DONE so the instruction leaves es at the end of that cycle.
- `hilo_we` is a single cycle, aligned with DONE. HI/LO update at the end of DONE.
- Back-to-back divides: DONE returns to IDLE, so the next divide in es starts one cycle after DONE.
- When `exc_flush` coincides with DONE, the write is suppressed.
- When `exc_flush` coincides with a start in IDLE, there is no start.

## Structure
- Shared pipeline package holds:
  - the state enum `div_state_t` (IDLE, RUN, DONE);
  - `DIV_WIDTH = 32`;
  - `DIV_CNT_W = $clog2(DIV_WIDTH)`.
- No sub-module. The restoring step is combinational inline logic next to the state register. HI/LO registers live outside the block.

## Test plan
- **DIVU**: 100 / 7 -> `div_block` high for 33 cycles, then `hilo_we` pulse with LO = 14, HI = 2.
- **DIV signed**: −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Also 7 / −2 -> LO = 0xFFFFFFFD, HI = 1.
- **Edge cases**: 0x80000000 / 0xFFFFFFFF signed -> LO = 0x80000000, HI = 0. And 5 / 0 DIVU -> LO = 0xFFFFFFFF, HI = 5.
- **Abort**: `exc_flush` at RUN cycle 10 -> IDLE next cycle and no `hilo_we`. Then a fresh divide 9 / 3 -> LO = 3, HI = 0.
- **Back-to-back and flush-at-DONE**: two back-to-back DIVUs -> second start exactly one cycle after the first DONE. `exc_flush` coincident with DONE -> `hilo_we` stays 0.
- **Reset mid-operation**: `resetn` low at RUN cycle 20 -> `busy` = 0 immediately and `hilo_we` = 0. After release with es idle, `div_block` = 0.
